sistema_cpu1_cpu_oci_monitor_mem: RTL and testbench

SISTEMA_CPU1_CPU_OCI_MONITOR_MEM -- requirements
Module: sistema_cpu1_cpu_oci_monitor_mem

---
 rtl/sistema_cpu1_cpu_oci_monitor_mem.sv | 208 ++++++++++++++++++++
 tb/tb_sistema_cpu1_cpu_oci_monitor_mem.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sistema_cpu1_cpu_oci_monitor_mem.sv
// OCI monitor RAM shared by the JTAG debug slave and the CPU data port.
// JTAG ops take 2-3 cycles; CPU reads 3 stall cycles + ack, CPU writes ack in one cycle.
module sistema_cpu1_cpu_oci_monitor_mem #(
  parameter int RAM_WORDS = 256,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  input  logic              debugaccess,
  output logic [31:0]       readdata,
  output logic              waitrequest,
  output logic [31:0]       MonDReg,
  output logic              jtag_overrun
);

  typedef enum logic [2:0] {
    IDLE, J_RD0, J_RD1, J_WR, C_RD0, C_RD1, C_ACK, C_WR
  } state_t;

  typedef enum logic [1:0] {K_NOACT, K_A, K_B} kind_t;

  typedef struct packed {
    kind_t             kind;
    logic              rd;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } jreq_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] mon_a_q, mon_a_d;
  logic [31:0]       mon_d_q, mon_d_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       wdat_q, wdat_d;
  logic              pend_vld_q, pend_vld_d;
  jreq_t             pend_q, pend_d;
  logic              cpu_turn_q, cpu_turn_d;
  logic              ovr_q, ovr_d;

  logic [31:0]       mem_q [RAM_WORDS];
  logic [31:0]       ram_rdat_q;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdat;

  logic              strobe_any;
  logic              cpu_req;
  jreq_t             arr;
  jreq_t             svc_req;
  logic              svc;
  logic              arr_taken;
  logic              unused_jdo;

  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

  assign strobe_any = take_action_ocimem_b | take_action_ocimem_a | take_no_action_ocimem_a;
  assign cpu_req    = chipselect & (read | write);

  always_comb begin
    arr.kind = take_action_ocimem_b ? K_B : (take_action_ocimem_a ? K_A : K_NOACT);
    arr.rd   = jdo[17];
    arr.addr = jdo[18 +: ADDR_W];
    arr.data = jdo[34:3];
  end

  always_comb begin
    state_d    = state_q;
    mon_a_d    = mon_a_q;
    mon_d_d    = mon_d_q;
    rdata_d    = rdata_q;
    wdat_d     = wdat_q;
    pend_vld_d = pend_vld_q;
    pend_d     = pend_q;
    cpu_turn_d = cpu_turn_q;
    ovr_d      = 1'b0;
    svc        = 1'b0;
    svc_req    = pend_q;
    arr_taken  = 1'b0;
    ram_we     = 1'b0;
    ram_be     = 4'hF;
    ram_addr   = address;
    ram_wdat   = writedata;

    case (state_q)
      IDLE: begin
        // A CPU request that waited through a JTAG op gets the next slot.
        cpu_turn_d = 1'b0;
        if (cpu_turn_q && cpu_req) begin
          state_d = read ? C_RD0 : C_WR;
        end else if (pend_vld_q) begin
          svc        = 1'b1;
          svc_req    = pend_q;
          pend_vld_d = 1'b0;
        end else if (strobe_any) begin
          svc       = 1'b1;
          svc_req   = arr;
          arr_taken = 1'b1;
        end else if (cpu_req) begin
          state_d = read ? C_RD0 : C_WR;
        end
      end
      J_RD0: begin
        ram_addr = mon_a_q;
        state_d  = J_RD1;
      end
      J_RD1: begin
        mon_d_d    = ram_rdat_q;
        mon_a_d    = mon_a_q + ADDR_W'(1);
        cpu_turn_d = 1'b1;
        state_d    = IDLE;
      end
      J_WR: begin
        ram_addr   = mon_a_q;
        ram_we     = 1'b1;
        ram_wdat   = wdat_q;
        mon_d_d    = wdat_q;
        mon_a_d    = mon_a_q + ADDR_W'(1);
        cpu_turn_d = 1'b1;
        state_d    = IDLE;
      end
      C_RD0: state_d = C_RD1;
      C_RD1: begin
        rdata_d = ram_rdat_q;
        state_d = C_ACK;
      end
      C_ACK: state_d = IDLE;
      C_WR: begin
        ram_we  = debugaccess;
        ram_be  = byteenable;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (svc) begin
      case (svc_req.kind)
        K_B: begin
          wdat_d  = svc_req.data;
          state_d = J_WR;
        end
        K_A: begin
          mon_a_d = svc_req.addr;
          if (svc_req.rd) state_d = J_RD0;
        end
        default: state_d = J_RD0;
      endcase
    end

    // One-deep pending slot; anything beyond it is dropped and flagged.
    if (strobe_any && !arr_taken) begin
      if (!pend_vld_d) begin
        pend_vld_d = 1'b1;
        pend_d     = arr;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      mon_a_q    <= '0;
      mon_d_q    <= '0;
      rdata_q    <= '0;
      wdat_q     <= '0;
      pend_vld_q <= 1'b0;
      pend_q     <= '0;
      cpu_turn_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mon_a_q    <= mon_a_d;
      mon_d_q    <= mon_d_d;
      rdata_q    <= rdata_d;
      wdat_q     <= wdat_d;
      pend_vld_q <= pend_vld_d;
      pend_q     <= pend_d;
      cpu_turn_q <= cpu_turn_d;
      ovr_q      <= ovr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_be[b]) mem_q[ram_addr][8*b +: 8] <= ram_wdat[8*b +: 8];
      end
    end
    ram_rdat_q <= mem_q[ram_addr];
  end

  assign waitrequest  = cpu_req & ~((state_q == C_ACK) || (state_q == C_WR));
  assign readdata     = rdata_q;
  assign MonDReg      = mon_d_q;
  assign jtag_overrun = ovr_q;

endmodule

// File: tb/tb_sistema_cpu1_cpu_oci_monitor_mem.sv
// Directed bench for the OCI monitor RAM: JTAG and CPU paths, arbitration, reset.
module tb_sistema_cpu1_cpu_oci_monitor_mem;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
  logic [7:0]  address;
  logic        chipselect, read, write, debugaccess;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata, MonDReg;
  logic        waitrequest, jtag_overrun;

  int n_cmp = 0;
  int n_err = 0;

  int          waits;
  logic [31:0] rdat;
  logic        wr_after;

  sistema_cpu1_cpu_oci_monitor_mem #(.RAM_WORDS(256), .ADDR_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .address(address), .chipselect(chipselect), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .debugaccess(debugaccess),
    .readdata(readdata), .waitrequest(waitrequest), .MonDReg(MonDReg),
    .jtag_overrun(jtag_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic jtag_a(input logic [7:0] a, input logic rd);
    jdo = '0;
    jdo[25:18] = a;
    jdo[17] = rd;
    take_action_ocimem_a = 1'b1;
    cyc();
    take_action_ocimem_a = 1'b0;
  endtask

  task automatic jtag_b(input logic [31:0] d);
    jdo = {3'b000, d, 3'b000};
    take_action_ocimem_b = 1'b1;
    cyc();
    take_action_ocimem_b = 1'b0;
  endtask

  task automatic jtag_n();
    take_no_action_ocimem_a = 1'b1;
    cyc();
    take_no_action_ocimem_a = 1'b0;
  endtask

  // Holds a CPU request until waitrequest drops, then one more cycle.
  task automatic cpu(input logic rd, input logic wr, input logic [7:0] a,
                     input logic [31:0] wd, input logic [3:0] be, input logic dbg,
                     output int nwait, output logic [31:0] rdv, output logic wra);
    chipselect = 1'b1; read = rd; write = wr; address = a;
    writedata = wd; byteenable = be; debugaccess = dbg;
    nwait = 0;
    while (nwait < 30) begin
      cyc();
      if (!waitrequest) break;
      nwait++;
    end
    rdv = readdata;
    cyc();
    wra = waitrequest;
    chipselect = 1'b0; read = 1'b0; write = 1'b0; debugaccess = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; jdo = '0;
    take_action_ocimem_a = 1'b0; take_no_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0;
    address = '0; chipselect = 1'b0; read = 1'b0; write = 1'b0;
    writedata = '0; byteenable = '0; debugaccess = 1'b0;

    // reset state
    cyc(); cyc();
    chk("rst MonDReg", MonDReg, 32'h0);
    chk("rst readdata", readdata, 32'h0);
    chk("rst waitrequest idle", {31'b0, waitrequest}, 32'h0);
    chk("rst overrun", {31'b0, jtag_overrun}, 32'h0);
    chk("rst MonAReg", {24'b0, dut.mon_a_q}, 32'h0);
    chipselect = 1'b1; read = 1'b1;
    #1;
    chk("rst waitrequest req", {31'b0, waitrequest}, 32'h1);
    chipselect = 1'b0; read = 1'b0;
    cyc();
    reset_n = 1'b1;
    cyc();

    // address load without read, then JTAG write
    jtag_a(8'h10, 1'b0);
    chk("a load MonAReg", {24'b0, dut.mon_a_q}, 32'h10);
    jtag_b(32'hDEADBEEF);
    chk("b MonDReg early", MonDReg, 32'h0);
    cyc();
    chk("b MonDReg", MonDReg, 32'hDEADBEEF);
    chk("b MonAReg inc", {24'b0, dut.mon_a_q}, 32'h11);
    jtag_b(32'h12345678);
    cyc();
    chk("b2 MonAReg", {24'b0, dut.mon_a_q}, 32'h12);

    // JTAG read via ocimem_a with jdo[17]=1, then no_action read
    jtag_a(8'h10, 1'b1);
    cyc();
    chk("rd MonDReg at k+1", MonDReg, 32'h12345678);
    cyc();
    chk("rd MonDReg at k+2", MonDReg, 32'hDEADBEEF);
    chk("rd MonAReg", {24'b0, dut.mon_a_q}, 32'h11);
    jtag_n();
    cyc(); cyc();
    chk("noact MonDReg", MonDReg, 32'h12345678);
    chk("noact MonAReg", {24'b0, dut.mon_a_q}, 32'h12);

    // address wrap
    jtag_a(8'hFF, 1'b0);
    jtag_b(32'h1);
    cyc();
    chk("wrap MonAReg", {24'b0, dut.mon_a_q}, 32'h0);
    chk("wrap MonDReg", MonDReg, 32'h1);
    jtag_a(8'hFF, 1'b1);
    cyc(); cyc();
    chk("wrap readback", MonDReg, 32'h1);

    // simultaneous strobes: b wins
    jtag_a(8'h60, 1'b0);
    jdo = {3'b000, 32'h60606060, 3'b000};
    take_action_ocimem_b = 1'b1; take_action_ocimem_a = 1'b1; take_no_action_ocimem_a = 1'b1;
    cyc();
    take_action_ocimem_b = 1'b0; take_action_ocimem_a = 1'b0; take_no_action_ocimem_a = 1'b0;
    chk("prio no overrun", {31'b0, jtag_overrun}, 32'h0);
    cyc();
    chk("prio MonDReg", MonDReg, 32'h60606060);
    chk("prio MonAReg", {24'b0, dut.mon_a_q}, 32'h61);
    jtag_a(8'h60, 1'b1);
    cyc(); cyc();
    chk("prio readback", MonDReg, 32'h60606060);

    // CPU writes with byte lanes and debugaccess gating
    cpu(1'b0, 1'b1, 8'h20, 32'h0, 4'hF, 1'b1, waits, rdat, wr_after);
    chk("cw0 waits", waits, 0);
    cpu(1'b0, 1'b1, 8'h20, 32'hAABBCCDD, 4'b0011, 1'b1, waits, rdat, wr_after);
    chk("cw1 waits", waits, 0);
    chk("cw1 wait after ack", {31'b0, wr_after}, 32'h1);
    cpu(1'b1, 1'b0, 8'h20, 32'h0, 4'hF, 1'b0, waits, rdat, wr_after);
    chk("cr1 waits", waits, 2);
    chk("cr1 data", rdat, 32'h0000CCDD);
    chk("cr1 wait after ack", {31'b0, wr_after}, 32'h1);
    cpu(1'b0, 1'b1, 8'h20, 32'hFFFFFFFF, 4'hF, 1'b0, waits, rdat, wr_after);
    chk("cw nodbg waits", waits, 0);
    chk("cw nodbg wait after ack", {31'b0, wr_after}, 32'h1);
    cpu(1'b1, 1'b1, 8'h20, 32'h11111111, 4'hF, 1'b1, waits, rdat, wr_after);
    chk("crw as read waits", waits, 2);
    chk("crw as read data", rdat, 32'h0000CCDD);
    jtag_a(8'h20, 1'b1);
    cyc(); cyc();
    chk("cpu ram via jtag", MonDReg, 32'h0000CCDD);

    // CPU read held across JTAG read + latched + dropped strobes
    jtag_a(8'h40, 1'b0);
    jtag_b(32'h40404040);
    cyc();
    jtag_b(32'h41414141);
    cyc();
    jtag_a(8'h40, 1'b0);
    chipselect = 1'b1; read = 1'b1; write = 1'b0; address = 8'h20;
    take_no_action_ocimem_a = 1'b1;
    cyc();
    chk("arb wait e1", {31'b0, waitrequest}, 32'h1);
    cyc();
    take_no_action_ocimem_a = 1'b0;
    chk("arb latch no overrun", {31'b0, jtag_overrun}, 32'h0);
    jdo = '0; jdo[25:18] = 8'h99; jdo[17] = 1'b1;
    take_action_ocimem_a = 1'b1;
    cyc();
    take_action_ocimem_a = 1'b0;
    chk("arb overrun pulse", {31'b0, jtag_overrun}, 32'h1);
    chk("arb jtag rd data", MonDReg, 32'h40404040);
    chk("arb wait e3", {31'b0, waitrequest}, 32'h1);
    cyc();
    chk("arb overrun one cycle", {31'b0, jtag_overrun}, 32'h0);
    chk("arb dropped no load", {24'b0, dut.mon_a_q}, 32'h41);
    chk("arb wait e4", {31'b0, waitrequest}, 32'h1);
    cyc();
    chk("arb wait e5", {31'b0, waitrequest}, 32'h1);
    cyc();
    chk("arb cpu ack", {31'b0, waitrequest}, 32'h0);
    chk("arb cpu data", readdata, 32'h0000CCDD);
    chk("arb jtag not yet", MonDReg, 32'h40404040);
    cyc();
    chk("arb wait after ack", {31'b0, waitrequest}, 32'h1);
    chipselect = 1'b0; read = 1'b0;
    cyc(); cyc(); cyc();
    chk("arb pending served", MonDReg, 32'h41414141);
    chk("arb pending MonAReg", {24'b0, dut.mon_a_q}, 32'h42);

    // reset during J_RD1
    jtag_a(8'h40, 1'b1);
    cyc();
    reset_n = 1'b0;
    #1;
    chk("mid rst MonDReg", MonDReg, 32'h0);
    chk("mid rst MonAReg", {24'b0, dut.mon_a_q}, 32'h0);
    jdo = {3'b000, 32'h00000BAD, 3'b000};
    take_action_ocimem_b = 1'b1;
    cyc();
    take_action_ocimem_b = 1'b0;
    cyc();
    reset_n = 1'b1;
    cyc();
    chk("post rst MonAReg", {24'b0, dut.mon_a_q}, 32'h0);
    chk("post rst MonDReg", MonDReg, 32'h0);
    chk("post rst overrun", {31'b0, jtag_overrun}, 32'h0);
    jtag_a(8'h41, 1'b1);
    cyc(); cyc();
    chk("post rst read", MonDReg, 32'h41414141);
    chk("post rst MonAReg inc", {24'b0, dut.mon_a_q}, 32'h42);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
